mem_stage_lsu: RTL and testbench
================================

MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 Parameter XLEN, default 32, data and address width; only 32 is supported.
REQ-002 Parameter DEPTH_WORDS, default 1024, number of 32-bit words in the internal data memory; power of two.
REQ-003 Parameter LATENCY, default 2, number of BUSY cycles per access; legal range 1..8.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 me_alu_o  input  XLEN  effective byte address.
REQ-007 me_regs_data2  input  XLEN  store data from the register file.
REQ-008 forward_data  input  1  when high, store data is taken from w_regs_data.
REQ-009 w_regs_data  input  XLEN  writeback-stage forwarded data.
REQ-010 me_mem_read  input  1  load request.
REQ-011 me_mem_write  input  1  store request.
REQ-012 me_funct3  input  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-013 me_mem_data  output  XLEN  registered load result.
REQ-014 me_stall  output  1  pipeline hold request.
REQ-015 me_done  output  1  one-cycle access-complete pulse.
REQ-016 me_access_err  output  1  one-cycle error pulse.

Function
REQ-017 The block SHALL implement a three-state FSM: IDLE, BUSY and DONE.
REQ-018 In IDLE, a request (read xor write) with no error SHALL be accepted, latching address, funct3, direction and muxed store data (w_regs_data if forward_data, else me_regs_data2), and the FSM SHALL move to BUSY with the counter loaded to LATENCY-1.
REQ-019 Error conditions are: read and write both high; illegal funct3 (011, 110, 111, or 100/101 on a store); H/HU with addr[0]=1; W with addr[1:0]!=0; word index addr>>2 >= DEPTH_WORDS.
REQ-020 On an error in IDLE, me_access_err SHALL pulse high for exactly that cycle (combinational), no memory access SHALL occur, the FSM SHALL stay in IDLE, and me_stall SHALL stay low.
REQ-021 me_stall SHALL be high combinationally in IDLE when a legal request is present, and in every BUSY cycle; it SHALL be low in DONE.
REQ-022 BUSY SHALL decrement the counter each cycle; at counter 0 the FSM SHALL go to DONE, for exactly LATENCY BUSY cycles.
REQ-023 On the BUSY-to-DONE edge, stores SHALL write memory with byte enables (SB: 1 lane by addr[1:0]; SH: 2 lanes by addr[1]; SW: 4 lanes), using low-order bytes of the latched store data.
REQ-024 On the same edge, loads SHALL register me_mem_data: lane selected by address, sign-extended for B/H, zero-extended for BU/HU.
REQ-025 me_mem_data SHALL hold its value until the next load completes; stores SHALL leave it unchanged.
REQ-026 In DONE, me_done SHALL be high for one cycle, and the FSM SHALL return to IDLE unconditionally; request inputs in DONE SHALL be ignored (they belong to the completing instruction).
REQ-027 Input changes during BUSY SHALL NOT affect the in-flight access.
REQ-028 Total accept-to-done latency SHALL be LATENCY+1 cycles; back-to-back accesses therefore take LATENCY+2 cycles each.

Reset
REQ-029 While rst is low, the FSM SHALL be IDLE, the counter 0, me_mem_data 0, and me_stall, me_done and me_access_err 0, asynchronously.
REQ-030 Memory contents SHALL NOT be reset.
REQ-031 Reset asserted during BUSY SHALL abort the access with no memory write.

Verification
REQ-032 LATENCY=2: SW 0xDEADBEEF @0x10, then LW @0x10 -> me_stall high 3 cycles per access, me_done pulse on the 4th, me_mem_data=0xDEADBEEF.
REQ-033 After REQ-032, SB 0x7F @0x13, then LB @0x13 -> 0x0000007F; LB @0x12 -> 0xFFFFFFAD; LBU @0x12 -> 0x000000AD; LW @0x10 -> 0x7FADBEEF.
REQ-034 SH 0x8001 @0x22, then LH @0x22 -> 0xFFFF8001; LHU @0x22 -> 0x00008001.
REQ-035 LW @0x11, LH @0x21, SB with funct3=100, read and write both high, LW @0x1000 (DEPTH_WORDS=1024) -> me_access_err one-cycle pulse each, me_stall low, memory and me_mem_data unchanged.
REQ-036 forward_data=1, w_regs_data=0x12345678, me_regs_data2=0 on SW @0x30, with inputs changed mid-BUSY -> LW @0x30 returns 0x12345678.
REQ-037 rst low during the BUSY of SW 0xFFFFFFFF @0x40 (previously 0x11111111) -> outputs zero immediately; after release, LW @0x40 returns 0x11111111.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: an IDLE/BUSY/DONE sequencer in front of a word-organised
// internal data memory, with byte/half/word accesses and fixed multi-cycle access latency.
module mem_stage_lsu #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] me_alu_o,
    input  logic [XLEN-1:0] me_regs_data2,
    input  logic            forward_data,
    input  logic [XLEN-1:0] w_regs_data,
    input  logic            me_mem_read,
    input  logic            me_mem_write,
    input  logic [2:0]      me_funct3,
    output logic [XLEN-1:0] me_mem_data,
    output logic            me_stall,
    output logic            me_done,
    output logic            me_access_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [2:0]      r_cnt;
    logic [AW+1:0]   r_addr;
    logic [2:0]      r_funct3;
    logic            r_write;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_mem_data;
    logic [31:0]     r_mem [DEPTH_WORDS];

    logic            w_req;
    logic            w_f3_bad;
    logic            w_misalign;
    logic            w_range;
    logic            w_err;
    logic            w_accept;
    logic            w_finish;
    logic [AW-1:0]   w_idx;
    logic [31:0]     w_st_word;
    logic [3:0]      w_be;
    logic [31:0]     w_rd_word;
    logic [7:0]      w_rd_byte;
    logic [15:0]     w_rd_half;
    logic [31:0]     w_load_val;

    // Request legality: size/sign encoding, natural alignment and address range.
    always_comb begin
        w_f3_bad   = 1'b0;
        w_misalign = 1'b0;
        case (me_funct3)
            3'b000: w_misalign = 1'b0;
            3'b001: w_misalign = me_alu_o[0];
            3'b010: w_misalign = |me_alu_o[1:0];
            3'b100: w_f3_bad   = me_mem_write;
            3'b101: begin
                w_f3_bad   = me_mem_write;
                w_misalign = me_alu_o[0];
            end
            default: w_f3_bad = 1'b1;
        endcase
    end

    assign w_req    = me_mem_read ^ me_mem_write;
    assign w_range  = |me_alu_o[XLEN-1:AW+2];
    assign w_err    = (me_mem_read & me_mem_write) | (w_req & (w_f3_bad | w_misalign | w_range));
    assign w_accept = w_req & ~w_err;
    assign w_finish = (r_state == S_BUSY) && (r_cnt == 3'd0);
    assign w_idx    = r_addr[AW+1:2];

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic; DONE always returns to IDLE so requests held in DONE are ignored.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_BUSY;
                else          w_next = S_IDLE;
            end
            S_BUSY: begin
                if (r_cnt == 3'd0) w_next = S_DONE;
                else               w_next = S_BUSY;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // FSM outputs; stall and error react to the request in the same cycle.
    always_comb begin
        me_stall      = 1'b0;
        me_access_err = 1'b0;
        me_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                me_stall      = w_accept;
                me_access_err = w_err;
            end
            S_BUSY:  me_stall = 1'b1;
            S_DONE:  me_done  = 1'b1;
            default: me_stall = 1'b0;
        endcase
    end

    // Latch the accepted request, run the latency counter and capture load results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= 3'd0;
            r_addr     <= '0;
            r_funct3   <= 3'd0;
            r_write    <= 1'b0;
            r_wdata    <= '0;
            r_mem_data <= '0;
        end else begin
            if (r_state == S_IDLE && w_accept) begin
                r_cnt    <= CNT_INIT;
                r_addr   <= me_alu_o[AW+1:0];
                r_funct3 <= me_funct3;
                r_write  <= me_mem_write;
                r_wdata  <= forward_data ? w_regs_data : me_regs_data2;
            end else if (r_state == S_BUSY && r_cnt != 3'd0) begin
                r_cnt <= r_cnt - 3'd1;
            end
            if (w_finish && !r_write) begin
                r_mem_data <= w_load_val;
            end
        end
    end

    // Store lane steering and byte enables.
    always_comb begin
        w_st_word = r_wdata;
        w_be      = 4'b0000;
        case (r_funct3[1:0])
            2'b00: begin
                w_st_word = r_wdata << {r_addr[1:0], 3'b000};
                w_be      = 4'b0001 << r_addr[1:0];
            end
            2'b01: begin
                w_st_word = r_addr[1] ? {r_wdata[15:0], 16'h0000} : {16'h0000, r_wdata[15:0]};
                w_be      = r_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    // Load lane extraction with sign/zero extension.
    always_comb begin
        w_rd_word = r_mem[w_idx];
        w_rd_byte = 8'(w_rd_word >> {r_addr[1:0], 3'b000});
        w_rd_half = r_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];
        case (r_funct3)
            3'b000:  w_load_val = {{24{w_rd_byte[7]}}, w_rd_byte};
            3'b001:  w_load_val = {{16{w_rd_half[15]}}, w_rd_half};
            3'b100:  w_load_val = {24'h000000, w_rd_byte};
            3'b101:  w_load_val = {16'h0000, w_rd_half};
            default: w_load_val = w_rd_word;
        endcase
    end

    // Data memory write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_finish && r_write) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_st_word[8*i +: 8];
            end
        end
    end

    assign me_mem_data = r_mem_data;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: a queue of expected me_mem_data values is filled when an
// access is issued and drained when its done pulse appears.
module tb_mem_stage_lsu;
    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] me_alu_o;
    logic [31:0] me_regs_data2;
    logic        forward_data;
    logic [31:0] w_regs_data;
    logic        me_mem_read;
    logic        me_mem_write;
    logic [2:0]  me_funct3;
    logic [31:0] me_mem_data;
    logic        me_stall;
    logic        me_done;
    logic        me_access_err;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] last_load = 32'h0;
    logic [31:0] sb_q[$];

    mem_stage_lsu #(.XLEN(32), .DEPTH_WORDS(1024), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst(rst), .me_alu_o(me_alu_o), .me_regs_data2(me_regs_data2),
        .forward_data(forward_data), .w_regs_data(w_regs_data), .me_mem_read(me_mem_read),
        .me_mem_write(me_mem_write), .me_funct3(me_funct3), .me_mem_data(me_mem_data),
        .me_stall(me_stall), .me_done(me_done), .me_access_err(me_access_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drop the request and put noise on every other input.
    task automatic scramble();
        me_mem_read   = 1'b0;
        me_mem_write  = 1'b0;
        me_alu_o      = $urandom;
        me_regs_data2 = $urandom;
        w_regs_data   = $urandom;
        forward_data  = 1'($urandom_range(0, 1));
        me_funct3     = 3'($urandom_range(0, 7));
    endtask

    task automatic access(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] data, input logic fwd,
                          input logic [31:0] wdata, input logic [31:0] exp_data);
        logic [31:0] stalls;
        logic        seen;
        logic [31:0] exp;
        @(negedge clk);
        me_mem_read   = rd;
        me_mem_write  = wr;
        me_funct3     = f3;
        me_alu_o      = addr;
        me_regs_data2 = data;
        forward_data  = fwd;
        w_regs_data   = wdata;
        sb_q.push_back(exp_data);
        stalls = 32'd0;
        seen   = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (me_done) begin
                seen = 1'b1;
                break;
            end
            if (me_stall) stalls++;
            @(negedge clk);
            scramble();
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_stall_cycles"}, stalls, 32'(LATENCY + 1));
        chk({tag, "_stall_in_done"}, 32'(me_stall), 32'd0);
        exp = sb_q.pop_front();
        chk({tag, "_data"}, me_mem_data, exp);
    endtask

    task automatic store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] data);
        access(tag, 1'b0, 1'b1, f3, addr, data, 1'b0, ~data, last_load);
    endtask

    task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] exp_data);
        last_load = exp_data;
        access(tag, 1'b1, 1'b0, f3, addr, 32'h0, 1'b0, 32'h0, exp_data);
    endtask

    task automatic bad_access(input string tag, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] dones;
        @(negedge clk);
        me_mem_read   = rd;
        me_mem_write  = wr;
        me_funct3     = f3;
        me_alu_o      = addr;
        me_regs_data2 = data;
        forward_data  = 1'b0;
        #1;
        chk({tag, "_err"}, 32'(me_access_err), 32'd1);
        chk({tag, "_stall"}, 32'(me_stall), 32'd0);
        @(negedge clk);
        scramble();
        #1;
        chk({tag, "_err_pulse_end"}, 32'(me_access_err), 32'd0);
        dones = 32'd0;
        for (int c = 0; c < LATENCY + 3; c++) begin
            if (me_done || me_stall) dones++;
            @(negedge clk);
            #1;
        end
        chk({tag, "_no_access"}, dones, 32'd0);
        chk({tag, "_data_kept"}, me_mem_data, last_load);
    endtask

    initial begin
        rst = 1'b0;
        scramble();
        #1;
        chk("reset_stall", 32'(me_stall), 32'd0);
        chk("reset_done", 32'(me_done), 32'd0);
        chk("reset_err", 32'(me_access_err), 32'd0);
        chk("reset_data", me_mem_data, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        store("sw_10", 3'b010, 32'h10, 32'hDEADBEEF);
        load("lw_10", 3'b010, 32'h10, 32'hDEADBEEF);
        store("sb_13", 3'b000, 32'h13, 32'hAAAAAA7F);
        load("lb_13", 3'b000, 32'h13, 32'h0000007F);
        load("lb_12", 3'b000, 32'h12, 32'hFFFFFFAD);
        load("lbu_12", 3'b100, 32'h12, 32'h000000AD);
        load("lw_10b", 3'b010, 32'h10, 32'h7FADBEEF);
        store("sh_22", 3'b001, 32'h22, 32'h55558001);
        load("lh_22", 3'b001, 32'h22, 32'hFFFF8001);
        load("lhu_22", 3'b101, 32'h22, 32'h00008001);

        bad_access("e_lw_11", 1'b1, 1'b0, 3'b010, 32'h11, 32'h0);
        bad_access("e_lh_21", 1'b1, 1'b0, 3'b001, 32'h21, 32'h0);
        bad_access("e_sbu", 1'b0, 1'b1, 3'b100, 32'h10, 32'h0);
        bad_access("e_rdwr", 1'b1, 1'b1, 3'b010, 32'h10, 32'h0);
        bad_access("e_range", 1'b1, 1'b0, 3'b010, 32'h1000, 32'h0);
        load("lw_10_after_err", 3'b010, 32'h10, 32'h7FADBEEF);

        access("sw_30_fwd", 1'b0, 1'b1, 3'b010, 32'h30, 32'h0, 1'b1, 32'h12345678, last_load);
        load("lw_30", 3'b010, 32'h30, 32'h12345678);

        store("sw_40", 3'b010, 32'h40, 32'h11111111);
        @(negedge clk);
        me_mem_read   = 1'b0;
        me_mem_write  = 1'b1;
        me_funct3     = 3'b010;
        me_alu_o      = 32'h40;
        me_regs_data2 = 32'hFFFFFFFF;
        forward_data  = 1'b0;
        #1;
        chk("abort_accept_stall", 32'(me_stall), 32'd1);
        @(negedge clk);
        scramble();
        rst = 1'b0;
        #1;
        chk("abort_stall", 32'(me_stall), 32'd0);
        chk("abort_done", 32'(me_done), 32'd0);
        chk("abort_err", 32'(me_access_err), 32'd0);
        chk("abort_data", me_mem_data, 32'h0);
        last_load = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        load("lw_40_after_abort", 3'b010, 32'h40, 32'h11111111);
        load("lw_10_mem_kept", 3'b010, 32'h10, 32'h7FADBEEF);

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
